// File: rtl/dff_pkg.sv
// Shared types and constants for the enable-gated D register family.
package dff_pkg;

   typedef enum logic {
      EN_HIGH = 1'b0,
      EN_LOW  = 1'b1
   } en_pol_e;

   localparam int unsigned DFF_DEF_WIDTH = 1;

endpackage

// File: rtl/dff_alpha.sv
// Legacy 1-bit flop with active-high enable, reset value 0.
// Carries clr when DFF_CLEAR_EN is defined.
module dff_alpha (
   input  logic clk,
   input  logic rst,
`ifdef DFF_CLEAR_EN
   input  logic clr,
`endif
   input  logic en,
   input  logic d,
   output logic q
);

   dff_en_reg #(
      .WIDTH         (1),
      .RST_VAL       (1'b0),
      .EN_ACTIVE_LOW (1'b0)
   ) u_reg (
      .clk (clk),
      .rst (rst),
`ifdef DFF_CLEAR_EN
      .clr (clr),
`endif
      .en  (en),
      .d   (d),
      .q   (q)
   );

endmodule

// File: rtl/dff_beta.sv
// Legacy 1-bit flop with active-low enable, reset value 0.
// Carries clr when DFF_CLEAR_EN is defined.
module dff_beta (
   input  logic clk,
   input  logic rst,
`ifdef DFF_CLEAR_EN
   input  logic clr,
`endif
   input  logic en,
   input  logic d,
   output logic q
);

   dff_en_reg #(
      .WIDTH         (1),
      .RST_VAL       (1'b0),
      .EN_ACTIVE_LOW (1'b1)
   ) u_reg (
      .clk (clk),
      .rst (rst),
`ifdef DFF_CLEAR_EN
      .clr (clr),
`endif
      .en  (en),
      .d   (d),
      .q   (q)
   );

endmodule

// File: rtl/dff_delta.sv
// Legacy 1-bit flop with active-low enable, reset value 0.
// Carries clr when DFF_CLEAR_EN is defined.
module dff_delta (
   input  logic clk,
   input  logic rst,
`ifdef DFF_CLEAR_EN
   input  logic clr,
`endif
   input  logic en,
   input  logic d,
   output logic q
);

   dff_en_reg #(
      .WIDTH         (1),
      .RST_VAL       (1'b0),
      .EN_ACTIVE_LOW (1'b1)
   ) u_reg (
      .clk (clk),
      .rst (rst),
`ifdef DFF_CLEAR_EN
      .clr (clr),
`endif
      .en  (en),
      .d   (d),
      .q   (q)
   );

endmodule

// File: rtl/dff_en_cell.sv
// Single-bit enable-gated flop with synchronous reset.
// Optional synchronous clear input when DFF_CLEAR_EN is defined.
module dff_en_cell #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
`ifdef DFF_CLEAR_EN
   input  logic clr,
`endif
   input  logic en_act,
   input  logic d,
   output logic q
);

   // Priority: reset, then clear (if built in), then load.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
`ifdef DFF_CLEAR_EN
      end else if (clr) begin
         q <= 1'b0;
`endif
      end else if (en_act) begin
         q <= d;
      end
   end

endmodule

// File: rtl/dff_en_reg.sv
// Clock-enabled D register, synchronous active-high reset, configurable enable polarity.
// Defining DFF_CLEAR_EN adds a synchronous clear input (clr) below reset in priority.
module dff_en_reg
   import dff_pkg::*;
#(
   parameter int unsigned     WIDTH         = DFF_DEF_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL      = '0,
   parameter bit              EN_ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
`ifdef DFF_CLEAR_EN
   input  logic             clr,
`endif
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   localparam en_pol_e EnPol = EN_ACTIVE_LOW ? EN_LOW : EN_HIGH;

   logic en_act;

   // Polarity decoded once, shared by every bit.
   assign en_act = (EnPol == EN_LOW) ? ~en : en;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_en_cell #(
         .RST_VAL (RST_VAL[i])
      ) u_cell (
         .clk    (clk),
         .rst    (rst),
`ifdef DFF_CLEAR_EN
         .clr    (clr),
`endif
         .en_act (en_act),
         .d      (d[i]),
         .q      (q[i])
      );
   end

endmodule

// File: tb/tb_dff_en_reg.sv
// Directed bench for dff_en_reg: high/low enable polarity and a 4-bit instance with
// RST_VAL=4'hA run in lockstep; clear tests are compiled in with DFF_CLEAR_EN.
module tb_dff_en_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_h;
   logic       en_l;
   logic       d1;
   logic [3:0] d4;
   logic       q_h;
   logic       q_l;
   logic [3:0] q4;
`ifdef DFF_CLEAR_EN
   logic       clr;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   dff_en_reg #(.WIDTH(1), .RST_VAL(1'b0), .EN_ACTIVE_LOW(1'b0)) u_hi (
      .clk (clk),
      .rst (rst),
`ifdef DFF_CLEAR_EN
      .clr (clr),
`endif
      .en  (en_h),
      .d   (d1),
      .q   (q_h)
   );

   dff_en_reg #(.WIDTH(1), .RST_VAL(1'b0), .EN_ACTIVE_LOW(1'b1)) u_lo (
      .clk (clk),
      .rst (rst),
`ifdef DFF_CLEAR_EN
      .clr (clr),
`endif
      .en  (en_l),
      .d   (d1),
      .q   (q_l)
   );

   dff_en_reg #(.WIDTH(4), .RST_VAL(4'hA), .EN_ACTIVE_LOW(1'b0)) u_w4 (
      .clk (clk),
      .rst (rst),
`ifdef DFF_CLEAR_EN
      .clr (clr),
`endif
      .en  (en_h),
      .d   (d4),
      .q   (q4)
   );

   task automatic set_en(input logic active);
      en_h = active;
      en_l = ~active;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_en(1'b0);
      d1  = 1'b0;
      d4  = 4'h5;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (q_h !== 1'b0) begin
            n_mis++; $display("FAIL reset[%0d] q_hi got %b want 0", i, q_h);
         end
         n_cmp++;
         if (q_l !== 1'b0) begin
            n_mis++; $display("FAIL reset[%0d] q_lo got %b want 0", i, q_l);
         end
         n_cmp++;
         if (q4 !== 4'hA) begin
            n_mis++; $display("FAIL reset[%0d] q_w4 got %h want a", i, q4);
         end
      end
   endtask

   task automatic test_hold();
      logic [2:0] dv1;
      logic [11:0] dv4;
      dv1 = 3'b010;
      dv4 = 12'hF30;
      rst = 1'b0;
      set_en(1'b0);
      for (int i = 0; i < 3; i++) begin
         d1 = dv1[2-i];
         d4 = dv4[(2-i)*4 +: 4];
         @(posedge clk); #1;
         n_cmp++;
         if (q_h !== 1'b0) begin
            n_mis++; $display("FAIL hold[%0d] q_hi got %b want 0", i, q_h);
         end
         n_cmp++;
         if (q_l !== 1'b0) begin
            n_mis++; $display("FAIL hold[%0d] q_lo got %b want 0", i, q_l);
         end
         n_cmp++;
         if (q4 !== 4'hA) begin
            n_mis++; $display("FAIL hold[%0d] q_w4 got %h want a", i, q4);
         end
      end
   endtask

   task automatic test_load();
      logic [2:0] dv1;
      logic [11:0] dv4;
      dv1 = 3'b010;
      dv4 = 12'h3C6;
      rst = 1'b0;
      set_en(1'b1);
      for (int i = 0; i < 3; i++) begin
         d1 = dv1[2-i];
         d4 = dv4[(2-i)*4 +: 4];
         @(posedge clk); #1;
         n_cmp++;
         if (q_h !== dv1[2-i]) begin
            n_mis++; $display("FAIL load[%0d] q_hi got %b want %b", i, q_h, dv1[2-i]);
         end
         n_cmp++;
         if (q_l !== dv1[2-i]) begin
            n_mis++; $display("FAIL load[%0d] q_lo got %b want %b", i, q_l, dv1[2-i]);
         end
         n_cmp++;
         if (q4 !== dv4[(2-i)*4 +: 4]) begin
            n_mis++;
            $display("FAIL load[%0d] q_w4 got %h want %h", i, q4, dv4[(2-i)*4 +: 4]);
         end
      end
   endtask

   // Load 1/5, then reset with enable active, then resume loading once reset drops.
   task automatic test_priority();
      logic [2:0]  rv;
      logic [2:0]  e1;
      logic [11:0] dv4;
      logic [11:0] e4;
      rv  = 3'b010;
      e1  = 3'b101;
      dv4 = 12'h5F9;
      e4  = 12'h5A9;
      set_en(1'b1);
      d1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rst = rv[2-i];
         d4  = dv4[(2-i)*4 +: 4];
         @(posedge clk); #1;
         n_cmp++;
         if (q_h !== e1[2-i]) begin
            n_mis++; $display("FAIL priority[%0d] q_hi got %b want %b", i, q_h, e1[2-i]);
         end
         n_cmp++;
         if (q_l !== e1[2-i]) begin
            n_mis++; $display("FAIL priority[%0d] q_lo got %b want %b", i, q_l, e1[2-i]);
         end
         n_cmp++;
         if (q4 !== e4[(2-i)*4 +: 4]) begin
            n_mis++;
            $display("FAIL priority[%0d] q_w4 got %h want %h", i, q4, e4[(2-i)*4 +: 4]);
         end
      end
   endtask

   // Wiggle every input between edges; q must not move until the edge, which sees en active.
   task automatic test_no_async();
      rst = 1'b0;
      d1  = 1'b0;
      d4  = 4'h0;
      set_en(1'b0);
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      set_en(1'b1);
      #1;
      n_cmp++;
      if (q_h !== 1'b1) begin
         n_mis++; $display("FAIL no_async q_hi got %b want 1", q_h);
      end
      n_cmp++;
      if (q_l !== 1'b1) begin
         n_mis++; $display("FAIL no_async q_lo got %b want 1", q_l);
      end
      n_cmp++;
      if (q4 !== 4'h9) begin
         n_mis++; $display("FAIL no_async q_w4 got %h want 9", q4);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (q_h !== 1'b0 || q_l !== 1'b0 || q4 !== 4'h0) begin
         n_mis++;
         $display("FAIL edge_after_toggle q_hi/q_lo/q_w4 got %b/%b/%h want 0/0/0", q_h, q_l, q4);
      end
   endtask

`ifdef DFF_CLEAR_EN
   task automatic test_clear();
      rst = 1'b0;
      clr = 1'b0;
      set_en(1'b1);
      d1 = 1'b1;
      d4 = 4'hF;
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (q_h !== 1'b0 || q_l !== 1'b0) begin
         n_mis++; $display("FAIL clear q_hi/q_lo got %b/%b want 0/0", q_h, q_l);
      end
      n_cmp++;
      if (q4 !== 4'h0) begin
         n_mis++; $display("FAIL clear q_w4 got %h want 0", q4);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (q4 !== 4'hA) begin
         n_mis++; $display("FAIL rst_over_clr q_w4 got %h want a", q4);
      end
      rst = 1'b0;
      clr = 1'b0;
   endtask
`endif

   initial begin
`ifdef DFF_CLEAR_EN
      clr = 1'b0;
`endif
      rst  = 1'b1;
      en_h = 1'b0;
      en_l = 1'b1;
      d1   = 1'b0;
      d4   = 4'h0;
      test_reset();
      test_hold();
      test_load();
      test_priority();
      test_no_async();
`ifdef DFF_CLEAR_EN
      test_clear();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
